mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port on-chip instruction/data RAM between two native-interface masters: port 0 is the CPU core, port 1 is the firmware loader/debug master.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the synchronous RAM (1-cycle read latency) and returns a one-cycle ready pulse to the granted master.
- Sits between the core and the RAM inside top.

Parameters:
- ADDR_W, 10, RAM word-address width (1024 x 32-bit words).
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m0_valid / m1_valid  in  1  request from port 0 / port 1
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write enables; 0 = read
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while ready=1
- m0_err / m1_err  out  1  pulse with ready when the address is out of range
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All ready, err and ram_en/ram_we outputs go to 0; rdata goes to 0.
  - last_grant=1, so port 0 wins the first contention.
- All outputs are registered.
- IDLE:
  - Neither valid: stay in IDLE.
  - Exactly one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - On grant: latch addr/wdata/wstrb and the grant id, update last_grant, go to ISSUE.
- Range check: off = addr - BASE_ADDR; in range iff off[31:ADDR_W+2]==0.
- ISSUE:
  - In range: ram_en=1, ram_addr=off[ADDR_W+1:2], ram_we=wstrb, ram_wdata=wdata; next state WAIT.
  - Out of range: no RAM strobe; next state DONE with err=1 and rdata=0.
- WAIT: ram_en=0; capture ram_rdata; go to DONE.
- DONE:
  - Granted port sees ready=1 for exactly one cycle, with rdata (captured value for reads, 0 for writes) and err.
  - Next state IDLE.
- Latency: valid sampled in IDLE at cycle N -> ready at cycle N+3 (in range) or N+2 (out of range).
- Masters hold valid and payload stable until ready (core protocol). The arbiter ignores valid during ISSUE/WAIT/DONE. A master that keeps valid high after ready is treated as a new request in the following IDLE cycle.
- Non-granted master: ready/err stay 0; rdata holds its previous value.
- Misaligned addr[1:0] is ignored (word access).
- Write with partial strobe: only the selected bytes are written; the RAM handles per-byte enables.
- Valid dropped mid-transaction (protocol violation): the transaction still completes and the ready pulse is still issued.
- Reset mid-transaction: transaction aborted, no ready issued, ram_en forced to 0 immediately.

Optional Feature:
- Macro: MEM_BUS_ARBITER_STATS_EN.
- Defined: adds outputs grant_cnt0[15:0], grant_cnt1[15:0] and contend_cnt[15:0].
  - grant_cnt0 / grant_cnt1 increment on each grant to that port.
  - contend_cnt increments on each IDLE cycle where both valids are high.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3
  - port id constants: PORT_CPU=1'b0, PORT_LDR=1'b1
  - default BASE_ADDR and ADDR_W
- One natural sub-module: mem_bus_rr_pick. It is a combinational 2-way round-robin picker taking valid[1:0] and last_grant, and returning gnt_id and any.
- Everything else stays in mem_bus_arbiter.

Test Plan:
1. Reset release, then m0 reads 0x0000_0010 with RAM word 4 = 0xDEADBEEF -> ram_en one cycle with ram_addr=4, ram_we=0; m0_ready=1 with m0_rdata=0xDEADBEEF exactly 3 cycles after valid; m1_ready stays 0.
2. m1 writes 0x0000_0008, wdata 0x12345678, wstrb 4'b0011 -> ram_we=4'b0011, ram_addr=2. A later m0 read of the same address returns the low half updated.
3. Both masters valid continuously for 4 transactions -> grant order 0,1,0,1; each ready pulse lasts 1 cycle; no overlapping ram_en.
4. m0 reads 0x0000_1000 with ADDR_W=10 -> no ram_en; m0_ready=1 and m0_err=1 with rdata=0, 2 cycles after valid.
5. rst pulsed low during WAIT -> ram_en=0 and ready=0 immediately. After release, a pending m1 request wins over a simultaneous m0 request? No: last_grant=1 after reset, so m0 wins.
6. With MEM_BUS_ARBITER_STATS_EN defined, run 3 contended cycles and 5 total grants (3 to m0, 2 to m1) -> contend_cnt=3, grant_cnt0=3, grant_cnt1=2.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared constants and types for the two-master RAM arbiter:
//   FSM state encoding, port ids, default RAM geometry, request struct
//   and the address range-check helper.
package mem_bus_arbiter_pkg;

  localparam int          DEF_ADDR_W    = 10;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // off is the byte offset from BASE_ADDR; everything above the word
  // index field must be zero for the access to land inside the RAM.
  function automatic logic addr_in_range(input logic [31:0] off, input int aw);
    return (off >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_bus_rr_pick.sv
// mem_bus_rr_pick
//   Combinational 2-way round-robin picker.
//   i_valid[1:0]  : request lines (bit 0 = CPU, bit 1 = loader)
//   i_last_grant  : id of the most recent grant
//   o_gnt_id      : id to grant this cycle (meaningful only when o_any)
//   o_any         : at least one request pending
module mem_bus_rr_pick (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_gnt_id,
  output logic       o_any
);

  always_comb begin
    o_any = |i_valid;
    // Under contention the port that did not win last time goes next;
    // otherwise the single requester (bit 1 set means loader).
    if (&i_valid) o_gnt_id = ~i_last_grant;
    else          o_gnt_id = i_valid[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares a single-port synchronous RAM (1-cycle read latency) between
//   the CPU (port 0) and the loader/debug master (port 1). Round-robin,
//   one transaction in flight, every output registered.
//   Ports:
//     clk, rst (async, active low)
//     m{0,1}_valid/addr/wdata/wstrb : master requests (wstrb==0 -> read)
//     m{0,1}_ready/rdata/err        : one-cycle completion pulse + data
//     ram_en/we/addr/wdata, ram_rdata : RAM side
//   Optional: define MEM_BUS_ARBITER_STATS_EN to add saturating counters
//     grant_cnt0, grant_cnt1, contend_cnt.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef MEM_BUS_ARBITER_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       contend_cnt
`endif
);

  state_e r_state, w_nxt;

  logic              r_last, r_gid, r_inr;
  logic [3:0]        r_wstrb;
  logic [1:0]        w_valid;
  logic              w_gid, w_any, w_inr_sel, w_grant;
  req_t              w_req_sel;
  logic [31:0]       w_off_sel;

  logic              r_ram_en,    w_ram_en_d;
  logic [3:0]        r_ram_we,    w_ram_we_d;
  logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr_d;
  logic [31:0]       r_ram_wdata, w_ram_wdata_d;
  logic [1:0]        r_rdy,   w_rdy_d;
  logic [1:0]        r_err,   w_err_d;
  logic [1:0][31:0]  r_rdata, w_rdata_d;

  assign w_valid = {m1_valid, m0_valid};

  mem_bus_rr_pick u_pick (
    .i_valid      (w_valid),
    .i_last_grant (r_last),
    .o_gnt_id     (w_gid),
    .o_any        (w_any)
  );

  assign w_req_sel = (w_gid == PORT_LDR) ? '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb}
                                         : '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_off_sel = w_req_sel.addr - BASE_ADDR;
  assign w_inr_sel = addr_in_range(w_off_sel, ADDR_W);
  assign w_grant   = (r_state == IDLE) && w_any;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_nxt = ISSUE;
      ISSUE:   w_nxt = r_inr ? WAIT : DONE;
      WAIT:    w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Output logic: computes the value each output register takes for the
  // coming state, so RAM strobes land in ISSUE and ready lands in DONE.
  always_comb begin
    w_ram_en_d    = 1'b0;
    w_ram_we_d    = '0;
    w_ram_addr_d  = r_ram_addr;
    w_ram_wdata_d = r_ram_wdata;
    w_rdy_d       = '0;
    w_err_d       = '0;
    w_rdata_d     = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_any && w_inr_sel) begin
          w_ram_en_d    = 1'b1;
          w_ram_we_d    = w_req_sel.wstrb;
          w_ram_addr_d  = w_off_sel[ADDR_W+1:2];
          w_ram_wdata_d = w_req_sel.wdata;
        end
      end
      ISSUE: begin
        if (!r_inr) begin
          w_rdy_d[r_gid]   = 1'b1;
          w_err_d[r_gid]   = 1'b1;
          w_rdata_d[r_gid] = '0;
        end
      end
      WAIT: begin
        w_rdy_d[r_gid]   = 1'b1;
        w_rdata_d[r_gid] = (r_wstrb == 4'd0) ? ram_rdata : 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdy       <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_last      <= PORT_LDR;
      r_gid       <= PORT_CPU;
      r_inr       <= 1'b0;
      r_wstrb     <= '0;
    end else begin
      r_ram_en    <= w_ram_en_d;
      r_ram_we    <= w_ram_we_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_wdata <= w_ram_wdata_d;
      r_rdy       <= w_rdy_d;
      r_err       <= w_err_d;
      r_rdata     <= w_rdata_d;
      if (w_grant) begin
        r_gid   <= w_gid;
        r_last  <= w_gid;
        r_inr   <= w_inr_sel;
        r_wstrb <= w_req_sel.wstrb;
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign m0_ready  = r_rdy[0];
  assign m1_ready  = r_rdy[1];
  assign m0_err    = r_err[0];
  assign m1_err    = r_err[1];
  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];

`ifdef MEM_BUS_ARBITER_STATS_EN
  logic [15:0] r_gcnt0, r_gcnt1, r_ccnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
      r_ccnt  <= '0;
    end else begin
      if (w_grant && (w_gid == PORT_CPU) && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
      if (w_grant && (w_gid == PORT_LDR) && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;
      if ((r_state == IDLE) && (&w_valid) && (r_ccnt != 16'hFFFF)) r_ccnt <= r_ccnt + 16'd1;
    end
  end

  assign grant_cnt0  = r_gcnt0;
  assign grant_cnt1  = r_gcnt1;
  assign contend_cnt = r_ccnt;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with a behavioural byte-enable RAM.
//   The RAM model reloads a few known words whenever rst is low.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef MEM_BUS_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, contend_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef MEM_BUS_ARBITER_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
    .contend_cnt (contend_cnt)
`endif
  );

  // Synchronous RAM, 1-cycle read latency, per-byte write enables.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (!rst) begin
      mem[2]    <= 32'hAABB_CCDD;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[1023] <= 32'h0BAD_F00D;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One single-master transaction; latency counted in posedges after valid.
  task automatic txn(input string tag, input logic p, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_er, input int exp_en, input logic [9:0] exp_ra,
                     input logic [3:0] exp_we);
    int          k   = 0;
    int          en  = 0;
    logic        got = 1'b0;
    logic [9:0]  ra  = '0;
    logic [3:0]  we  = '0;
    logic [31:0] rd  = '0;
    logic        er  = 1'b0;
    logic        oth = 1'b0;
    @(posedge clk); #1;
    if (p) begin m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; end
    else   begin m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; end
    while (!got && k < 10) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (ram_en) begin en++; ra = ram_addr; we = ram_we; end
      if (p ? m1_ready : m0_ready) begin
        got = 1'b1;
        rd  = p ? m1_rdata : m0_rdata;
        er  = p ? m1_err : m0_err;
        oth = p ? m0_ready : m1_ready;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk({tag, "_got"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_other_rdy"}, 32'(oth), 32'd0);
    chk({tag, "_en_cnt"}, en, exp_en);
    if (exp_en != 0) begin
      chk({tag, "_ram_addr"}, 32'(ra), 32'(exp_ra));
      chk({tag, "_ram_we"}, 32'(we), 32'(exp_we));
    end
    @(posedge clk); @(negedge clk);
    chk({tag, "_rdy_drop"}, 32'(p ? m1_ready : m0_ready), 32'd0);
  endtask

  // Both masters hold valid (m0 reads 0x10, m1 reads 0x8) for n transactions.
  task automatic run_both(input string tag, input int n, input logic [31:0] rd0,
                          input logic [31:0] rd1, input logic first);
    int   k = 0, got = 0, ovl = 0, en_cnt = 0;
    logic prev_rdy = 1'b0, prev_en = 1'b0, exp_p = first;
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'd0;
    m1_valid = 1'b1; m1_addr = 32'h08; m1_wstrb = 4'd0;
    while (got < n && k < 60) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (ram_en && prev_en) ovl++;
      if (ram_en) en_cnt++;
      prev_en = ram_en;
      if (m0_ready && m1_ready) ovl++;
      if (m0_ready || m1_ready) begin
        chk($sformatf("%s_order%0d", tag, got), 32'(m1_ready), 32'(exp_p));
        chk($sformatf("%s_rdata%0d", tag, got), m1_ready ? m1_rdata : m0_rdata, m1_ready ? rd1 : rd0);
        chk($sformatf("%s_pulse%0d", tag, got), 32'(prev_rdy), 32'd0);
        exp_p = ~exp_p;
        got++;
        if (got == n) begin m0_valid = 1'b0; m1_valid = 1'b0; end
      end
      prev_rdy = m0_ready | m1_ready;
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_overlap"}, ovl, 0);
    chk({tag, "_en_cnt"}, en_cnt, n);
    @(posedge clk); @(negedge clk);
    chk({tag, "_rdy_drop"}, 32'(m0_ready | m1_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_m0_err", 32'(m0_err), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b1;

    // Basic read, misaligned read, partial write + read-back, boundary, out of range
    txn("t1",   1'b0, 32'h0000_0010, 32'd0, 4'd0, 3, 32'hDEAD_BEEF, 1'b0, 1, 10'd4, 4'd0);
    txn("t2m",  1'b1, 32'h0000_0013, 32'd0, 4'd0, 3, 32'hDEAD_BEEF, 1'b0, 1, 10'd4, 4'd0);
    txn("t2w",  1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 3, 32'd0, 1'b0, 1, 10'd2, 4'b0011);
    txn("t2r",  1'b0, 32'h0000_0008, 32'd0, 4'd0, 3, 32'hAABB_5678, 1'b0, 1, 10'd2, 4'd0);
    txn("tmax", 1'b1, 32'h0000_0FFC, 32'd0, 4'd0, 3, 32'h0BAD_F00D, 1'b0, 1, 10'd1023, 4'd0);
    txn("t4",   1'b0, 32'h0000_1000, 32'd0, 4'd0, 2, 32'd0, 1'b1, 0, 10'd0, 4'd0);
    txn("t4w",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 2, 32'd0, 1'b1, 0, 10'd0, 4'd0);

    // Contention right after reset: CPU first, then strict alternation
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_both("t3", 4, 32'hDEAD_BEEF, 32'hAABB_CCDD, 1'b0);

    // Reset mid-transaction (RAM strobe active): strobe clears at once,
    // no ready pulse follows, and arbitration restarts with CPU priority.
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'd0;
    @(posedge clk); @(negedge clk);
    chk("t5_issue_en", 32'(ram_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_rst_en", 32'(ram_en), 32'd0);
    chk("t5_rst_rdy", 32'(m0_ready), 32'd0);
    m0_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t5_no_rdy", 32'(m0_ready), 32'd0);
    @(negedge clk);
    chk("t5_no_en", 32'(ram_en), 32'd0);
    run_both("t5", 2, 32'hDEAD_BEEF, 32'hAABB_CCDD, 1'b0);

`ifdef MEM_BUS_ARBITER_STATS_EN
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_g0", 32'(grant_cnt0), 32'd0);
    chk("t6_rst_c", 32'(contend_cnt), 32'd0);
    rst = 1'b1;
    run_both("t6", 3, 32'hDEAD_BEEF, 32'hAABB_CCDD, 1'b0);
    txn("t6a", 1'b0, 32'h0000_0010, 32'd0, 4'd0, 3, 32'hDEAD_BEEF, 1'b0, 1, 10'd4, 4'd0);
    txn("t6b", 1'b1, 32'h0000_0008, 32'd0, 4'd0, 3, 32'hAABB_CCDD, 1'b0, 1, 10'd2, 4'd0);
    chk("t6_grant0", 32'(grant_cnt0), 32'd3);
    chk("t6_grant1", 32'(grant_cnt1), 32'd2);
    chk("t6_contend", 32'(contend_cnt), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
